ram_bist_seq: RTL and testbench
===============================

RAM_BIST_SEQ -- requirements
Module: ram_bist_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width (64-word RAM).
REQ-002 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port Start  input  1  begin a test run; sampled only in IDLE.
REQ-005 SHALL have port Abort  input  1  synchronous cancel of a running test.
REQ-006 SHALL have port Pattern_Sel  input  2  data pattern select.
REQ-007 SHALL have port Mem_Addr  output  ADDR_W  RAM word address (connects to Mem_Addr[7:2] of the RAM stage).
REQ-008 SHALL have port Mem_Write  output  1  RAM write enable.
REQ-009 SHALL have port M_W_Data  output  32  RAM write data.
REQ-010 SHALL have port M_R_Data  input  32  RAM read data; synchronous RAM, 1-cycle read latency.
REQ-011 SHALL have port Busy  output  1  test in progress.
REQ-012 SHALL have port Done  output  1  one-cycle pulse at test completion.
REQ-013 SHALL have port Pass  output  1  result of last completed test.
REQ-014 SHALL have port Err_Cnt  output  8  mismatch count, saturating.
REQ-015 SHALL have port First_Err_Addr  output  ADDR_W  address of first mismatch.

Function
REQ-016 SHALL implement FSM states IDLE, WRITE, READ, DRAIN, DONE.
REQ-017 SHALL drive Mem_Addr, Mem_Write, M_W_Data, Busy, Done, Pass, Err_Cnt, First_Err_Addr directly from flops.
REQ-018 SHALL compute pattern P(a) per address a: 00 -> 32'h0002_0003; 01 -> each byte = a zero-extended/truncated to 8 bits; 10 -> 32'h1234_5678 XOR pattern-01 value; 11 -> 32'hAAAA_AAAA for even a, 32'h5555_5555 for odd a.
REQ-019 SHALL latch Pattern_Sel at Start acceptance and use the latched value for the whole run.
REQ-020 SHALL, at the edge sampling Start=1 in IDLE: enter WRITE, set Busy=1, Mem_Write=1, Mem_Addr=0, M_W_Data=P(0), clear Err_Cnt, Pass, First_Err_Addr.
REQ-021 SHALL, in WRITE, advance Mem_Addr by 1 and M_W_Data to P(Mem_Addr+1) each cycle, writing all 2^ADDR_W words exactly once.
REQ-022 SHALL, at the edge after the last-word write is presented, enter READ with Mem_Write=0, Mem_Addr=0.
REQ-023 SHALL, in READ, issue addresses 0..2^ADDR_W-1 one per cycle, then enter DRAIN for exactly one cycle.
REQ-024 SHALL compare M_R_Data against P(a) on the edge one clock after the RAM captured address a, using a delayed-address/valid pipeline register; last compare occurs in DRAIN.
REQ-025 SHALL increment Err_Cnt per mismatch, saturating at 255.
REQ-026 SHALL load First_Err_Addr only on the first mismatch of a run; it then holds.
REQ-027 SHALL, from DRAIN, enter DONE: Busy=0, Done=1 for one cycle, Pass=1 iff final Err_Cnt==0; then return to IDLE.
REQ-028 SHALL keep Busy=1 for exactly 2*2^ADDR_W+1 cycles per uninterrupted run (129 for ADDR_W=6).
REQ-029 SHALL ignore Start outside IDLE.
REQ-030 SHALL, on Abort=1 in WRITE/READ/DRAIN, enter IDLE at next edge with Mem_Write=0, Busy=0, no Done, Pass=0; Err_Cnt and First_Err_Addr hold.
REQ-031 SHALL give Abort priority over any simultaneous state advance; Abort in IDLE/DONE has no effect.
REQ-032 SHALL hold Pass, Err_Cnt, First_Err_Addr stable in IDLE until next accepted Start.

Reset
REQ-033 SHALL, while Rst_n=0, immediately force state IDLE and all outputs to 0, including Mem_Write=0 so no RAM write occurs mid-reset.
REQ-034 SHALL clear the compare pipeline on reset so no compare fires in the first cycles after release.

Verification
REQ-035 SHALL verify clean run: ADDR_W=6, ideal RAM model, Pattern_Sel=00 -> Busy high 129 cycles, Done one pulse, Pass=1, Err_Cnt=0.
REQ-036 SHALL verify write data: Pattern_Sel=01 -> write at Mem_Addr=3 carries 32'h0303_0303; Pattern_Sel=10 at addr 3 -> 32'h1137_557B.
REQ-037 SHALL verify faults: Pattern_Sel=11, RAM bit0 stuck-at-0 at words 4,5,9 -> Err_Cnt=2, First_Err_Addr=5, Pass=0.
REQ-038 SHALL verify saturation: ADDR_W=8, RAM always returns 0, Pattern_Sel=11 -> 256 mismatches, Err_Cnt=255, Pass=0.
REQ-039 SHALL verify Abort in READ at address 20 plus Start pulse during WRITE -> Start ignored; IDLE next edge, Busy=0, Mem_Write=0, no Done, Pass=0.
REQ-040 SHALL verify Rst_n low asynchronously mid-WRITE at Mem_Addr=10 -> Mem_Write=0 and Busy=0 before next edge; after release, Start runs a normal 129-cycle test.

Source files
------------

// File: rtl/ram_bist_seq.sv
// March-style RAM self-test sequencer: writes a selectable pattern to every word,
// reads it all back through a 1-cycle synchronous RAM, and reports mismatches.
module ram_bist_seq #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic [1:0]        Pattern_Sel,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Write,
  output logic [31:0]       M_W_Data,
  input  logic [31:0]       M_R_Data,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic [7:0]        Err_Cnt,
  output logic [ADDR_W-1:0] First_Err_Addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [7:0]        ERR_MAX   = 8'hFF;

  state_e state_q, state_d;

  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [7:0]        err_q, err_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;

  logic              running_c;
  logic              last_addr_c;
  logic              mismatch_c;
  logic [ADDR_W-1:0] addr_inc_c;
  logic [7:0]        err_upd_c;
  logic [ADDR_W-1:0] first_upd_c;

  function automatic logic [31:0] pattern(input logic [1:0] sel, input logic [ADDR_W-1:0] a);
    logic [7:0]  byte_v;
    logic [31:0] rep;
    logic [31:0] res;
    byte_v = 8'(a);
    rep    = {byte_v, byte_v, byte_v, byte_v};
    case (sel)
      2'b00:   res = 32'h0002_0003;
      2'b01:   res = rep;
      2'b10:   res = 32'h1234_5678 ^ rep;
      default: res = a[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
    endcase
    return res;
  endfunction

  assign running_c   = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign last_addr_c = (mem_addr_q == LAST_ADDR);
  assign addr_inc_c  = mem_addr_q + ADDR_W'(1);

  // Compare the word the RAM captured on the previous edge; an abort discards it.
  assign mismatch_c  = cmp_vld_q && !Abort && (M_R_Data != pattern(sel_q, cmp_addr_q));
  assign err_upd_c   = (mismatch_c && (err_q != ERR_MAX)) ? err_q + 8'd1 : err_q;
  assign first_upd_c = (mismatch_c && (err_q == 8'd0)) ? cmp_addr_q : first_err_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_WRITE;
      S_WRITE: if (Abort) state_d = S_IDLE; else if (last_addr_c) state_d = S_READ;
      S_READ:  if (Abort) state_d = S_IDLE; else if (last_addr_c) state_d = S_DRAIN;
      S_DRAIN: state_d = Abort ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_d       = sel_q;
    mem_addr_d  = mem_addr_q;
    mem_write_d = mem_write_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_upd_c;
    first_err_d = first_upd_c;
    cmp_vld_d   = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    if (running_c && Abort) begin
      mem_addr_d  = '0;
      mem_write_d = 1'b0;
      busy_d      = 1'b0;
      pass_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            sel_d       = Pattern_Sel;
            mem_addr_d  = '0;
            mem_write_d = 1'b1;
            wdata_d     = pattern(Pattern_Sel, '0);
            busy_d      = 1'b1;
            pass_d      = 1'b0;
            err_d       = 8'd0;
            first_err_d = '0;
          end
        end
        S_WRITE: begin
          if (last_addr_c) begin
            mem_write_d = 1'b0;
            mem_addr_d  = '0;
          end else begin
            mem_addr_d = addr_inc_c;
            wdata_d    = pattern(sel_q, addr_inc_c);
          end
        end
        S_READ: begin
          cmp_vld_d  = 1'b1;
          cmp_addr_d = mem_addr_q;
          mem_addr_d = last_addr_c ? '0 : addr_inc_c;
        end
        S_DRAIN: begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_upd_c == 8'd0);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sel_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      wdata_q     <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 8'd0;
      first_err_q <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_addr_q  <= '0;
    end else begin
      sel_q       <= sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_write_q <= mem_write_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  assign Mem_Addr       = mem_addr_q;
  assign Mem_Write      = mem_write_q;
  assign M_W_Data       = wdata_q;
  assign Busy           = busy_q;
  assign Done           = done_q;
  assign Pass           = pass_q;
  assign Err_Cnt        = err_q;
  assign First_Err_Addr = first_err_q;

endmodule

// File: tb/tb_ram_bist_seq.sv
// Bench for ram_bist_seq: behavioural RAMs with fault injection and a pattern/fault model.
module tb_ram_bist_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start6 = 1'b0, abort6 = 1'b0;
  logic [1:0]  sel6 = 2'd0;
  logic [5:0]  ma6;
  logic        mw6;
  logic [31:0] wd6, rd6;
  logic        busy6, done6, pass6;
  logic [7:0]  err6;
  logic [5:0]  first6;

  logic        start8 = 1'b0;
  logic [1:0]  sel8 = 2'd0;
  logic [7:0]  ma8;
  logic        mw8;
  logic [31:0] wd8;
  logic        busy8, done8, pass8;
  logic [7:0]  err8;
  logic [7:0]  first8;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mem6 [64];
  bit          fault6 [64];
  int          fbit6 = 0;

  always #5 clk = ~clk;

  ram_bist_seq #(.ADDR_W(6)) dut6 (
    .Clk(clk), .Rst_n(rst_n), .Start(start6), .Abort(abort6), .Pattern_Sel(sel6),
    .Mem_Addr(ma6), .Mem_Write(mw6), .M_W_Data(wd6), .M_R_Data(rd6),
    .Busy(busy6), .Done(done6), .Pass(pass6), .Err_Cnt(err6), .First_Err_Addr(first6)
  );

  // Second instance: 256-word RAM that always reads back zero.
  ram_bist_seq #(.ADDR_W(8)) dut8 (
    .Clk(clk), .Rst_n(rst_n), .Start(start8), .Abort(1'b0), .Pattern_Sel(sel8),
    .Mem_Addr(ma8), .Mem_Write(mw8), .M_W_Data(wd8), .M_R_Data(32'h0),
    .Busy(busy8), .Done(done8), .Pass(pass8), .Err_Cnt(err8), .First_Err_Addr(first8)
  );

  // Synchronous RAM, 1-cycle read latency, optional stuck-at-0 bit on chosen words.
  always @(posedge clk) begin
    if (mw6) mem6[ma6] <= wd6;
    rd6 <= fault6[ma6] ? (mem6[ma6] & ~(32'h1 << fbit6)) : mem6[ma6];
  end

  function automatic logic [31:0] ref_pat(input int sel, input int a);
    logic [31:0] rep;
    rep = 32'(a % 256) * 32'h0101_0101;
    case (sel)
      0:       return 32'h0002_0003;
      1:       return rep;
      2:       return 32'h1234_5678 ^ rep;
      default: return (a % 2 == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
    endcase
  endfunction

  // Mismatches the RAM faults cause over addresses 0..upto-1 (unsaturated).
  function automatic int model_errs(input int sel, input int upto, output int first);
    int n;
    logic [31:0] stored, rd;
    n = 0;
    first = 0;
    for (int a = 0; a < upto; a++) begin
      stored = ref_pat(sel, a);
      rd = fault6[a] ? (stored & ~(32'h1 << fbit6)) : stored;
      if (rd != stored) begin
        if (n == 0) first = a;
        n++;
      end
    end
    return n;
  endfunction

  task automatic clear_faults;
    for (int a = 0; a < 64; a++) fault6[a] = 1'b0;
    fbit6 = 0;
  endtask

  // Drives one full run on dut6 and reports what was observed.
  task automatic run6(input int sel, output int busy_cyc, output int done_cnt, output int wr_cnt,
                      output int wr_bad, output logic [31:0] w3, output logic pass_o,
                      output logic [7:0] err_o, output logic [5:0] first_o, output bit timed_out);
    int cyc;
    bit seen;
    busy_cyc = 0; done_cnt = 0; wr_cnt = 0; wr_bad = 0; w3 = 32'hx;
    pass_o = 1'bx; err_o = 8'hx; first_o = 6'hx; seen = 1'b0; cyc = 0;
    @(negedge clk); sel6 = 2'(sel); start6 = 1'b1;
    @(negedge clk); start6 = 1'b0;
    while (!seen && cyc < 400) begin
      if (busy6) busy_cyc++;
      if (mw6) begin
        wr_cnt++;
        if (ma6 == 6'd3) w3 = wd6;
        if (wd6 !== ref_pat(sel, int'(ma6))) wr_bad++;
      end
      if (done6) begin
        seen = 1'b1; done_cnt++; pass_o = pass6; err_o = err6; first_o = first6;
      end
      @(negedge clk); cyc++;
    end
    timed_out = !seen;
    repeat (3) begin
      if (done6) done_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if ({mw6, busy6, done6, pass6} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {mw6, busy6, done6, pass6}); end
    n_cmp++; if ({ma6, wd6, err6, first6} !== '0) begin n_fail++; $display("FAIL reset_data6: got addr=%0h wd=%0h err=%0d first=%0d want all 0", ma6, wd6, err6, first6); end
    n_cmp++; if ({ma8, mw8, wd8, busy8, done8, pass8, err8, first8} !== '0) begin n_fail++; $display("FAIL reset_dut8: got nonzero outputs want all 0"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy6, mw6, err6} !== 10'b0) begin n_fail++; $display("FAIL reset_release: got busy=%b mw=%b err=%0d want 0", busy6, mw6, err6); end
  endtask

  task automatic test_clean_run;
    int bc, dc, wc, wb; logic [31:0] w3; logic p; logic [7:0] e; logic [5:0] f; bit to;
    clear_faults();
    run6(0, bc, dc, wc, wb, w3, p, e, f, to);
    n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL clean_timeout: got %b want 0", to); end
    n_cmp++; if (bc !== 129) begin n_fail++; $display("FAIL clean_busy: got %0d want 129", bc); end
    n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL clean_done: got %0d want 1", dc); end
    n_cmp++; if (wc !== 64 || wb !== 0) begin n_fail++; $display("FAIL clean_writes: got cnt=%0d bad=%0d want 64/0", wc, wb); end
    n_cmp++; if (p !== 1'b1 || e !== 8'd0) begin n_fail++; $display("FAIL clean_result: got pass=%b err=%0d want 1/0", p, e); end
  endtask

  task automatic test_write_data;
    int bc, dc, wc, wb; logic [31:0] w3; logic p; logic [7:0] e; logic [5:0] f; bit to;
    clear_faults();
    run6(1, bc, dc, wc, wb, w3, p, e, f, to);
    n_cmp++; if (w3 !== 32'h0303_0303) begin n_fail++; $display("FAIL wdata_p01: got %h want 03030303", w3); end
    n_cmp++; if (wb !== 0 || p !== 1'b1) begin n_fail++; $display("FAIL wdata_p01_run: got bad=%0d pass=%b want 0/1", wb, p); end
    run6(2, bc, dc, wc, wb, w3, p, e, f, to);
    n_cmp++; if (w3 !== 32'h1137_557B) begin n_fail++; $display("FAIL wdata_p10: got %h want 1137557b", w3); end
    n_cmp++; if (wb !== 0 || p !== 1'b1) begin n_fail++; $display("FAIL wdata_p10_run: got bad=%0d pass=%b want 0/1", wb, p); end
  endtask

  task automatic test_faults;
    int bc, dc, wc, wb, exp_n, exp_f; logic [31:0] w3; logic p; logic [7:0] e; logic [5:0] f; bit to;
    clear_faults();
    fault6[4] = 1'b1; fault6[5] = 1'b1; fault6[9] = 1'b1;
    exp_n = model_errs(3, 64, exp_f);
    run6(3, bc, dc, wc, wb, w3, p, e, f, to);
    n_cmp++; if (e !== 8'(exp_n) || e !== 8'd2) begin n_fail++; $display("FAIL fault_err: got %0d want %0d", e, exp_n); end
    n_cmp++; if (f !== 6'(exp_f) || f !== 6'd5) begin n_fail++; $display("FAIL fault_first: got %0d want %0d", f, exp_f); end
    n_cmp++; if (p !== 1'b0 || dc !== 1 || bc !== 129) begin n_fail++; $display("FAIL fault_run: got pass=%b done=%0d busy=%0d want 0/1/129", p, dc, bc); end
    // Abort and a changed Pattern_Sel while idle must not disturb the held result.
    @(negedge clk); abort6 = 1'b1; sel6 = 2'd0;
    @(negedge clk); abort6 = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if ({busy6, pass6, err6, first6} !== {1'b0, 1'b0, 8'd2, 6'd5}) begin n_fail++; $display("FAIL idle_hold: got busy=%b pass=%b err=%0d first=%0d want 0/0/2/5", busy6, pass6, err6, first6); end
  endtask

  task automatic test_random;
    int bc, dc, wc, wb, exp_n, exp_f, sel; logic [31:0] w3; logic p; logic [7:0] e; logic [5:0] f; bit to;
    for (int r = 0; r < 4; r++) begin
      sel = int'($urandom_range(3));
      clear_faults();
      fbit6 = int'($urandom_range(31));
      for (int a = 0; a < 64; a++) fault6[a] = ($urandom_range(7) == 0);
      exp_n = model_errs(sel, 64, exp_f);
      if (exp_n > 255) exp_n = 255;
      run6(sel, bc, dc, wc, wb, w3, p, e, f, to);
      n_cmp++; if (e !== 8'(exp_n) || f !== 6'(exp_f)) begin n_fail++; $display("FAIL rand%0d_err: got err=%0d first=%0d want %0d/%0d", r, e, f, exp_n, exp_f); end
      n_cmp++; if (p !== (exp_n == 0) || bc !== 129 || wb !== 0) begin n_fail++; $display("FAIL rand%0d_run: got pass=%b busy=%0d wbad=%0d want %b/129/0", r, p, bc, wb, exp_n == 0); end
    end
  endtask

  task automatic test_abort;
    int cyc, exp_n, exp_f; logic [5:0] prev; logic [7:0] e_before; bit found; int dcnt;
    clear_faults();
    fbit6 = 31;
    for (int a = 0; a < 64; a++) fault6[a] = 1'b1;
    @(negedge clk); sel6 = 2'd3; start6 = 1'b1;
    @(negedge clk); start6 = 1'b0;
    repeat (5) @(negedge clk);
    prev = ma6; start6 = 1'b1; sel6 = 2'd1;
    @(negedge clk); start6 = 1'b0;
    n_cmp++; if (ma6 !== 6'(prev + 6'd1) || mw6 !== 1'b1 || wd6 !== ref_pat(3, int'(ma6))) begin n_fail++; $display("FAIL start_ignored: got addr=%0d mw=%b wd=%h want %0d/1/%h", ma6, mw6, wd6, prev + 6'd1, ref_pat(3, int'(prev) + 1)); end
    found = 1'b0; cyc = 0;
    while (!found && cyc < 300) begin
      if (busy6 && !mw6 && ma6 == 6'd20) found = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL abort_reach: got no READ at addr 20 want reached"); end
    exp_n = model_errs(3, 19, exp_f);
    e_before = err6;
    n_cmp++; if (e_before !== 8'(exp_n)) begin n_fail++; $display("FAIL abort_pre_err: got %0d want %0d", e_before, exp_n); end
    abort6 = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({busy6, mw6, done6, pass6} !== 4'b0) begin n_fail++; $display("FAIL abort_state: got busy=%b mw=%b done=%b pass=%b want 0000", busy6, mw6, done6, pass6); end
    n_cmp++; if (err6 !== 8'(exp_n) || first6 !== 6'(exp_f)) begin n_fail++; $display("FAIL abort_hold: got err=%0d first=%0d want %0d/%0d", err6, first6, exp_n, exp_f); end
    @(negedge clk); abort6 = 1'b0;
    dcnt = 0;
    repeat (6) begin
      if (done6 || busy6) dcnt++;
      @(negedge clk);
    end
    n_cmp++; if (dcnt !== 0) begin n_fail++; $display("FAIL abort_idle: got %0d busy/done cycles want 0", dcnt); end
  endtask

  task automatic test_reset_mid_write;
    int cyc, bc, dc, wc, wb; logic [31:0] w3; logic p; logic [7:0] e; logic [5:0] f; bit to, found;
    clear_faults();
    @(negedge clk); sel6 = 2'd1; start6 = 1'b1;
    @(negedge clk); start6 = 1'b0;
    found = 1'b0; cyc = 0;
    while (!found && cyc < 100) begin
      if (mw6 && ma6 == 6'd10) found = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rst_reach: got no write at addr 10 want reached"); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({mw6, busy6, ma6} !== 8'b0) begin n_fail++; $display("FAIL rst_async: got mw=%b busy=%b addr=%0d want 0/0/0", mw6, busy6, ma6); end
    @(negedge clk); rst_n = 1'b1;
    run6(0, bc, dc, wc, wb, w3, p, e, f, to);
    n_cmp++; if (bc !== 129 || dc !== 1 || p !== 1'b1 || e !== 8'd0 || to) begin n_fail++; $display("FAIL rst_rerun: got busy=%0d done=%0d pass=%b err=%0d want 129/1/1/0", bc, dc, p, e); end
  endtask

  task automatic test_saturation;
    int busy_cyc, done_cnt, wr_cnt, wr_bad, cyc, exp_n; bit seen; logic p; logic [7:0] e, f;
    busy_cyc = 0; done_cnt = 0; wr_cnt = 0; wr_bad = 0; cyc = 0; seen = 1'b0;
    p = 1'bx; e = 8'hx; f = 8'hx;
    exp_n = 0;
    for (int a = 0; a < 256; a++) if (ref_pat(3, a) != 32'h0) exp_n++;
    if (exp_n > 255) exp_n = 255;
    @(negedge clk); sel8 = 2'd3; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    while (!seen && cyc < 1200) begin
      if (busy8) busy_cyc++;
      if (mw8) begin
        wr_cnt++;
        if (wd8 !== ref_pat(3, int'(ma8))) wr_bad++;
      end
      if (done8) begin seen = 1'b1; done_cnt++; p = pass8; e = err8; f = first8; end
      @(negedge clk); cyc++;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL sat_timeout: got no Done want Done"); end
    n_cmp++; if (e !== 8'(exp_n) || p !== 1'b0 || f !== 8'd0) begin n_fail++; $display("FAIL sat_err: got err=%0d pass=%b first=%0d want %0d/0/0", e, p, f, exp_n); end
    n_cmp++; if (busy_cyc !== 513 || wr_cnt !== 256 || wr_bad !== 0) begin n_fail++; $display("FAIL sat_run: got busy=%0d writes=%0d bad=%0d want 513/256/0", busy_cyc, wr_cnt, wr_bad); end
  endtask

  initial begin
    clear_faults();
    test_reset();
    test_clean_run();
    test_write_data();
    test_faults();
    test_random();
    test_abort();
    test_reset_mid_write();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
